bayer_line_buffer: RTL and testbench
====================================

// Module: bayer_line_buffer
// PURPOSE
//  Raw-Bayer line buffer at the head of the demosaic path, between sensor input and horizontal_shift_reg/window_builder.
//  Holds two previous scanlines. Emits one vertical 3-pixel column per beat (top, centre, bottom) with centre (x,y).
//  Top and bottom frame edges are handled by row replication. Valid/ready on both sides; flushes the last row after the frame ends.
// PARAMETERS
//  DATA_WIDTH  12    raw pixel width
//  IMG_WIDTH   1920  pixels per line (>=2)
//  IMG_HEIGHT  1080  lines per frame (>=2)
//  X_WIDTH     12    column counter width; must hold IMG_WIDTH-1
//  Y_WIDTH     12    row counter width; must hold IMG_HEIGHT-1
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous active-high reset
//  in_valid   in   1           input pixel valid
//  in_ready   out  1           input pixel accepted when in_valid & in_ready
//  in_pixel   in   DATA_WIDTH  raw Bayer sample, raster order
//  in_sof     in   1           qualifies the accepted pixel as the frame's (0,0) pixel
//  out_valid  out  1           output column valid
//  out_ready  in   1           downstream accepts when out_valid & out_ready
//  out_top    out  DATA_WIDTH  pixel at (x, y-1)
//  out_mid    out  DATA_WIDTH  pixel at (x, y), the centre
//  out_bot    out  DATA_WIDTH  pixel at (x, y+1)
//  out_x      out  X_WIDTH     centre column
//  out_y      out  Y_WIDTH     centre row
//  out_eof    out  1           marks beat with out_x=IMG_WIDTH-1 and out_y=IMG_HEIGHT-1
// BEHAVIOUR
//  Reset: out_valid=0; out_top/mid/bot/x/y/eof=0; in counters (ix,iy)=0; flush column=0; state=FILL.
//   in_ready=0 while rst is high.
//  Storage: two IMG_WIDTH-deep line memories. LA holds row iy-1; LB holds row iy-2.
//   Each accepted pixel reads LA[ix] and LB[ix], then writes LB[ix]<=LA[ix] and LA[ix]<=in_pixel in the same cycle.
//  Output register: one stage.
//   Loads on a produce event when (!out_valid | out_ready); otherwise holds.
//   out_valid clears on handshake when nothing new is produced. Data is stable while out_valid & !out_ready.
//  in_ready = !rst & state!=FLUSH & (!out_valid | out_ready). No combinational in_valid->in_ready path.
//  Latency: an accepted pixel appears at the output on the next cycle.
//  Counters: ix increments per accepted pixel and wraps at IMG_WIDTH-1, then iy increments.
//   An accepted pixel with in_sof=1 is treated as (0,0) regardless of the counters.
//   The abandoned partial frame is not flushed. State goes to FILL. Line memory contents are not cleared.
//  States:
//   FILL   (iy==0): stores only, no output.
//          Last pixel of row 0 -> STREAM.
//   STREAM (1<=iy<=IMG_HEIGHT-1): each accept produces centre (ix, iy-1) with
//          top = (iy==1) ? LA[ix] : LB[ix], mid = LA[ix], bot = in_pixel.
//          Last pixel of the frame -> FLUSH with fx=0.
//   FLUSH: no input accepted. Each output slot produces centre (fx, IMG_HEIGHT-1) with
//          top = LB[fx] (post-shift contents), mid = LA[fx], bot = mid.
//          fx advances per loaded beat. Beat fx=IMG_WIDTH-1 sets out_eof, then state=FILL with ix=iy=0.
//  out_eof is high only on the final beat of the frame.
//  Exactly IMG_WIDTH*IMG_HEIGHT output beats are produced per complete frame, in raster order of the centre.
//  Reset mid-frame or mid-flush: all state returns to reset values on the next clock. No stale beat is emitted.
// TESTING
//  IMG_WIDTH=4, IMG_HEIGHT=3, pixel=16*y+x, out_ready=1, no gaps
//   -> no output during row 0; beats (x,0): top=x, mid=x, bot=16+x.
//  Same frame -> beats (x,1): top=x, mid=16+x, bot=32+x.
//   Flush beats (x,2): top=16+x, mid=32+x, bot=32+x. out_eof only on (3,2). 12 beats total.
//  out_ready held 0 for 5 cycles at beat (1,1)
//   -> in_ready=0 during stall; output holds top=1, mid=17, bot=33; no beat lost or duplicated.
//  Second frame back-to-back after out_eof -> identical 12-beat sequence. in_ready stays low throughout the flush.
//  in_sof pulsed on the pixel at ix=2, iy=1 of frame 1
//   -> counters restart at (0,0); no output until the new row 0 completes; the new frame yields 12 correct beats.
//  rst asserted during the flush of beat (1,2)
//   -> next cycle out_valid=0 and in_ready=0; after release, a fresh frame yields 12 correct beats.

Source files
------------

// File: rtl/bayer_line_buffer.sv
// ---------------------------------------------------------------------------
// bayer_line_buffer
//   Raw-Bayer line buffer at the head of the demosaic path. Keeps the two
//   previous scanlines and emits one vertical 3-pixel column (top, mid, bot)
//   per beat, centred on (out_x, out_y). The top and bottom frame edges are
//   handled by row replication. After the last input pixel of a frame the
//   final row is flushed out without consuming input.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake, raster-order pixels
//   in_pixel                 raw Bayer sample
//   in_sof                   accepted pixel is the frame's (0,0) pixel
//   out_valid/out_ready      output handshake
//   out_top/out_mid/out_bot  pixels at (x,y-1), (x,y), (x,y+1)
//   out_x/out_y              centre coordinates
//   out_eof                  last beat of the frame
// ---------------------------------------------------------------------------
module bayer_line_buffer #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_WIDTH  = 1920,
   parameter int IMG_HEIGHT = 1080,
   parameter int X_WIDTH    = 12,
   parameter int Y_WIDTH    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_pixel,
   input  logic                  in_sof,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_top,
   output logic [DATA_WIDTH-1:0] out_mid,
   output logic [DATA_WIDTH-1:0] out_bot,
   output logic [X_WIDTH-1:0]    out_x,
   output logic [Y_WIDTH-1:0]    out_y,
   output logic                  out_eof
);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMG_WIDTH - 1);
   localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMG_HEIGHT - 1);

   // LA holds row iy-1, LB holds row iy-2
   logic [DATA_WIDTH-1:0] r_la [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] r_lb [IMG_WIDTH];

   state_t               r_state;
   logic [X_WIDTH-1:0]   r_ix;
   logic [Y_WIDTH-1:0]   r_iy;
   logic [X_WIDTH-1:0]   r_fx;

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_top;
   logic [DATA_WIDTH-1:0] r_out_mid;
   logic [DATA_WIDTH-1:0] r_out_bot;
   logic [X_WIDTH-1:0]    r_out_x;
   logic [Y_WIDTH-1:0]    r_out_y;
   logic                  r_out_eof;

   logic                  w_slot;
   logic                  w_accept;
   logic                  w_stream_beat;
   logic                  w_flush_beat;
   logic                  w_produce;
   logic [X_WIDTH-1:0]    w_wr_addr;
   logic [X_WIDTH-1:0]    w_rd_addr;
   logic [DATA_WIDTH-1:0] w_la_rd;
   logic [DATA_WIDTH-1:0] w_lb_rd;
   logic [DATA_WIDTH-1:0] w_nxt_top;
   logic [DATA_WIDTH-1:0] w_nxt_mid;
   logic [DATA_WIDTH-1:0] w_nxt_bot;
   logic [X_WIDTH-1:0]    w_nxt_x;
   logic [Y_WIDTH-1:0]    w_nxt_y;
   logic                  w_nxt_eof;

   // Output slot is free when empty or being drained this cycle
   assign w_slot   = !r_out_valid || out_ready;
   assign in_ready = !rst && (r_state != ST_FLUSH) && w_slot;
   assign w_accept = in_valid && in_ready;

   // An SOF pixel always lands at column 0 and never produces a beat
   assign w_wr_addr     = in_sof ? '0 : r_ix;
   assign w_rd_addr     = (r_state == ST_FLUSH) ? r_fx : w_wr_addr;
   assign w_la_rd       = r_la[w_rd_addr];
   assign w_lb_rd       = r_lb[w_rd_addr];
   assign w_stream_beat = w_accept && !in_sof && (r_state == ST_STREAM);
   assign w_flush_beat  = (r_state == ST_FLUSH) && w_slot;
   assign w_produce     = w_stream_beat || w_flush_beat;

   // Next output column: flush replicates mid as bottom, first stream row replicates LA as top
   always_comb begin
      w_nxt_top = w_lb_rd;
      w_nxt_mid = w_la_rd;
      w_nxt_bot = in_pixel;
      w_nxt_x   = r_ix;
      w_nxt_y   = r_iy - Y_WIDTH'(1);
      w_nxt_eof = 1'b0;
      if (r_state == ST_FLUSH) begin
         w_nxt_top = w_lb_rd;
         w_nxt_bot = w_la_rd;
         w_nxt_x   = r_fx;
         w_nxt_y   = Y_LAST;
         w_nxt_eof = (r_fx == X_LAST);
      end else begin
         w_nxt_top = (r_iy == Y_WIDTH'(1)) ? w_la_rd : w_lb_rd;
         w_nxt_bot = in_pixel;
      end
   end

   // Line memories: shift LA into LB and store the new pixel on every accept
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb[w_wr_addr] <= w_la_rd;
         r_la[w_wr_addr] <= in_pixel;
      end
   end

   // Control state, raster counters and the output register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_ix        <= '0;
         r_iy        <= '0;
         r_fx        <= '0;
         r_out_valid <= 1'b0;
         r_out_top   <= '0;
         r_out_mid   <= '0;
         r_out_bot   <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_out_eof   <= 1'b0;
      end else begin
         if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out_top   <= w_nxt_top;
            r_out_mid   <= w_nxt_mid;
            r_out_bot   <= w_nxt_bot;
            r_out_x     <= w_nxt_x;
            r_out_y     <= w_nxt_y;
            r_out_eof   <= w_nxt_eof;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_accept) begin
            if (in_sof) begin
               // Restart the frame; the pixel just taken is (0,0)
               r_state <= ST_FILL;
               r_ix    <= X_WIDTH'(1);
               r_iy    <= '0;
            end else if (r_ix == X_LAST) begin
               r_ix <= '0;
               if (r_iy == Y_LAST) begin
                  r_state <= ST_FLUSH;
                  r_fx    <= '0;
               end else begin
                  r_iy    <= r_iy + Y_WIDTH'(1);
                  r_state <= ST_STREAM;
               end
            end else begin
               r_ix <= r_ix + X_WIDTH'(1);
            end
         end else if (w_flush_beat) begin
            if (r_fx == X_LAST) begin
               r_state <= ST_FILL;
               r_fx    <= '0;
               r_ix    <= '0;
               r_iy    <= '0;
            end else begin
               r_fx <= r_fx + X_WIDTH'(1);
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_top   = r_out_top;
   assign out_mid   = r_out_mid;
   assign out_bot   = r_out_bot;
   assign out_x     = r_out_x;
   assign out_y     = r_out_y;
   assign out_eof   = r_out_eof;

endmodule

// File: tb/tb_bayer_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_bayer_line_buffer
//   Directed bench for bayer_line_buffer with a 4x3 frame, pixel = 16*y + x.
//   A negedge monitor checks every accepted output beat against the expected
//   column for its position in the frame.
// ---------------------------------------------------------------------------
module tb_bayer_line_buffer;

   localparam int DW = 12;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int XW = 3;
   localparam int YW = 2;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_pixel;
   logic          in_sof;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_top;
   logic [DW-1:0] out_mid;
   logic [DW-1:0] out_bot;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_eof;

   int n_total;
   int n_bad;
   int exp_k;
   int frames_done;
   int beats_total;

   bayer_line_buffer #(
      .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_WIDTH(XW), .Y_WIDTH(YW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_top(out_top), .out_mid(out_mid), .out_bot(out_bot),
      .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted beat must be the next column in raster order
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         int x, y, top, mid, bot;
         x   = exp_k % W;
         y   = exp_k / W;
         mid = 16 * y + x;
         top = (y == 0) ? mid : 16 * (y - 1) + x;
         bot = (y == H - 1) ? mid : 16 * (y + 1) + x;
         check("beat_x", int'(out_x), x);
         check("beat_y", int'(out_y), y);
         check("beat_top", int'(out_top), top);
         check("beat_mid", int'(out_mid), mid);
         check("beat_bot", int'(out_bot), bot);
         check("beat_eof", int'(out_eof), (exp_k == W * H - 1) ? 1 : 0);
         if (exp_k >= W * (H - 1) && exp_k < W * H - 1)
            check("flush_in_ready", int'(in_ready), 0);
         beats_total++;
         if (exp_k == W * H - 1) begin
            exp_k = 0;
            frames_done++;
         end else begin
            exp_k++;
         end
      end
   end

   task automatic send_pixel(input int px, input bit sof);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_pixel = DW'(px);
      in_sof   = sof;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("send_timeout", 0, 1);
      in_sof = 1'b0;
   endtask

   task automatic send_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            send_pixel(16 * y + x, (x == 0 && y == 0));
   endtask

   task automatic wait_frames(input int n);
      int c;
      c = 0;
      while (frames_done < n && c < 500) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("frames_reached", frames_done, n);
   endtask

   task automatic wait_beat(input int x, input int y);
      int c;
      c = 0;
      while (!(out_valid && int'(out_x) == x && int'(out_y) == y) && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("wait_beat_found", (c < 200) ? 1 : 0, 1);
   endtask

   initial begin
      n_total = 0; n_bad = 0; exp_k = 0; frames_done = 0; beats_total = 0;
      rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_top", int'(out_top), 0);
      check("rst_out_x", int'(out_x), 0);
      check("rst_out_eof", int'(out_eof), 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", int'(in_ready), 1);

      // Frame 1 with a 5-cycle downstream stall on beat (1,1)
      fork
         begin
            send_frame();
         end
         begin
            wait_beat(1, 1);
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("stall_in_ready", int'(in_ready), 0);
               check("stall_valid", int'(out_valid), 1);
               check("stall_top", int'(out_top), 1);
               check("stall_mid", int'(out_mid), 17);
               check("stall_bot", int'(out_bot), 33);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      // Frame 2 back-to-back; input waits through the flush of frame 1
      send_frame();
      in_valid = 1'b0;
      wait_frames(2);
      check("beats_after_2", beats_total, 24);

      // Partial frame abandoned by SOF at (2,1)
      for (int i = 0; i < W + 2; i++)
         send_pixel(16 * (i / W) + (i % W), (i == 0));
      send_pixel(0, 1'b1);
      check("abandoned_beats", exp_k, 2);
      exp_k = 0;
      check("sof_no_out", int'(out_valid), 0);
      for (int x = 1; x < W; x++) begin
         send_pixel(x, 1'b0);
         check("sof_fill_no_out", int'(out_valid), 0);
      end
      for (int i = W; i < W * H; i++)
         send_pixel(16 * (i / W) + (i % W), 1'b0);
      in_valid = 1'b0;
      wait_frames(3);

      // Reset during the flush of beat (1,2)
      send_frame();
      in_valid = 1'b0;
      wait_beat(1, 2);
      rst = 1'b1;
      #1;
      check("rst_mid_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      check("rst_mid_out_valid", int'(out_valid), 0);
      check("rst_mid_in_ready2", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_k = 0;
      @(posedge clk);
      #1;
      check("post_rst_no_out", int'(out_valid), 0);
      send_frame();
      in_valid = 1'b0;
      wait_frames(4);
      check("beats_total", beats_total, 12 + 12 + 2 + 12 + 9 + 12);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
